// File: rtl/verif_comp_b_pkg.sv
// verif_comp_b: shared mode constants, op codes and LFSR helpers
// for the multi-channel B-side responder.
package verif_comp_b_pkg;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_FIXED  = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [1:0] MODE_STALL  = 2'd3;

  localparam logic OP_INCR = 1'b0;
  localparam logic OP_LFSR = 1'b1;

  localparam logic [2:0] OP_ADD2 = 3'd0;
  localparam logic [2:0] OP_ADD3 = 3'd1;
  localparam logic [2:0] OP_SUB2 = 3'd2;
  localparam logic [2:0] OP_SUB3 = 3'd3;
  localparam logic [2:0] OP_MUL2 = 3'd4;
  localparam logic [2:0] OP_MUL3 = 3'd5;
  localparam logic [2:0] OP_MAX  = 3'd6;
  localparam logic [2:0] OP_AVG  = 3'd7;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE_NR = 2'b00,
    IDLE_R  = 2'b01,
    REQ     = 2'b10,
    HS      = 2'b11
  } ch_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  function automatic logic [15:0] chan_seed(input logic [15:0] seed,
                                            input int c);
    logic [15:0] s;
    s = seed ^ 16'(c);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/verif_comp_b_chan.sv
// verif_comp_b_chan: one responder channel with backpressure,
// op-code generation, handshake counter, capture and protocol check.
module verif_comp_b_chan
  import verif_comp_b_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          OP_W       = 3,
  parameter int          WAIT_W     = 5,
  parameter int          CNT_W      = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          RESET_WAIT = 1,
  parameter int          RESET_OP   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid,
  input  logic [DATA_W-1:0] result,
  input  logic [1:0]        ready_mode,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic              op_mode,
  input  logic              clr_err,
  output logic              ready,
  output logic [OP_W-1:0]   operation,
  output logic [CNT_W-1:0]  hs_count,
  output logic [DATA_W-1:0] last_result,
  output logic              proto_err
);

  logic [WAIT_W-1:0] w;
  logic [WAIT_W-1:0] w_nx;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nx;
  logic [15:0]       lfsr_adv;
  logic [OP_W-1:0]   op_nx;
  ch_state_e         st;
  ch_state_e         prev_st;
  logic [DATA_W-1:0] prev_res;
  logic              err_set;

  always_comb begin
    ready = 1'b0;
    unique case (ready_mode)
      MODE_ALWAYS: ready = 1'b1;
      MODE_STALL:  ready = 1'b0;
      default:     ready = (w == '0);
    endcase
  end

  assign st       = ch_state_e'({valid, ready});
  assign lfsr_adv = lfsr_next(lfsr);

  always_comb begin
    w_nx    = w;
    lfsr_nx = lfsr;
    op_nx   = operation;
    unique case (st)
      HS: begin
        lfsr_nx = lfsr_adv;
        unique case (ready_mode)
          MODE_ALWAYS: w_nx = '0;
          MODE_FIXED:  w_nx = cfg_wait;
          MODE_RANDOM: w_nx = lfsr_adv[WAIT_W-1:0] & cfg_wait;
          default:     w_nx = w;
        endcase
        if (op_mode == OP_LFSR)
          op_nx = lfsr_adv[15 -: OP_W];
        else
          op_nx = operation + 1'b1;
      end
      REQ: begin
        if (w != '0)
          w_nx = w - 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A pending request must keep valid and result stable.
  assign err_set = (prev_st == REQ) &&
                   (!valid || (result != prev_res));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w           <= WAIT_W'(RESET_WAIT);
      lfsr        <= SEED;
      operation   <= OP_W'(RESET_OP);
      hs_count    <= '0;
      last_result <= '0;
      proto_err   <= 1'b0;
      prev_st     <= IDLE_NR;
      prev_res    <= '0;
    end else begin
      w         <= w_nx;
      lfsr      <= lfsr_nx;
      operation <= op_nx;
      if (st == HS) begin
        last_result <= result;
        if (hs_count != '1)
          hs_count <= hs_count + 1'b1;
      end
      proto_err <= err_set | (proto_err & ~clr_err);
      prev_st   <= st;
      prev_res  <= result;
    end
  end

endmodule

// File: rtl/verif_comp_b_mc.sv
// verif_comp_b_mc: NUM_CH independent B-side responder channels
// sharing one configuration, with flat sliced ports.
module verif_comp_b_mc
  import verif_comp_b_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_W     = 32,
  parameter int          OP_W       = 3,
  parameter int          WAIT_W     = 5,
  parameter int          CNT_W      = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          RESET_WAIT = 1,
  parameter int          RESET_OP   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        b_valid,
  input  logic [NUM_CH*DATA_W-1:0] b_result,
  output logic [NUM_CH-1:0]        b_ready,
  output logic [NUM_CH*OP_W-1:0]   b_operation,
  input  logic [1:0]               cfg_ready_mode,
  input  logic [WAIT_W-1:0]        cfg_wait,
  input  logic                     cfg_op_mode,
  input  logic                     clr_err,
  output logic [NUM_CH*CNT_W-1:0]  hs_count,
  output logic [NUM_CH*DATA_W-1:0] last_result,
  output logic [NUM_CH-1:0]        proto_err
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    verif_comp_b_chan #(
      .DATA_W     (DATA_W),
      .OP_W       (OP_W),
      .WAIT_W     (WAIT_W),
      .CNT_W      (CNT_W),
      .SEED       (chan_seed(SEED, c)),
      .RESET_WAIT (RESET_WAIT),
      .RESET_OP   (RESET_OP)
    ) u_chan (
      .clk         (clk),
      .rstn        (rstn),
      .valid       (b_valid[c]),
      .result      (b_result[c*DATA_W +: DATA_W]),
      .ready_mode  (cfg_ready_mode),
      .cfg_wait    (cfg_wait),
      .op_mode     (cfg_op_mode),
      .clr_err     (clr_err),
      .ready       (b_ready[c]),
      .operation   (b_operation[c*OP_W +: OP_W]),
      .hs_count    (hs_count[c*CNT_W +: CNT_W]),
      .last_result (last_result[c*DATA_W +: DATA_W]),
      .proto_err   (proto_err[c])
    );
  end

endmodule
